// File: rtl/pip_pkg.sv
// ----------------------------------------------------------------------------
// pip_pkg
// Definitions shared by every pipeline stage. It holds the state encoding of
// the skid register and the default payload and counter widths, so all
// stages agree on them.
// ----------------------------------------------------------------------------
package pip_pkg;

    // Occupancy of a skid register.
    //   EMPTY : no entry is valid
    //   FULL  : the main entry is valid
    //   SKID  : the main and skid entries are both valid
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } skid_state_t;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_CTRL_WIDTH = 8;
    localparam int DEF_CNT_WIDTH  = 16;

endpackage : pip_pkg

// File: rtl/sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// Up-counter that saturates at all-ones. A clear in the same cycle as an
// increment wins.
//
// Ports
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   inc    : add one this cycle (ignored once the counter is saturated)
//   clr    : synchronous clear to zero; takes priority over inc
//   count  : current count
// ----------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    // NOTE: sequential state is written only with non-blocking assignments.
    // Every register then samples values from before the edge, whatever
    // order the blocks are evaluated in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule : sat_counter

// File: rtl/pip_skid_reg.sv
// ----------------------------------------------------------------------------
// pip_skid_reg
// Two-entry pipeline register with a valid/ready handshake on both sides.
// The main entry drives the outputs. The skid entry catches a beat that
// arrives while the downstream stage is stalled. Because of the skid entry,
// ready_out is a function of registered state only, so no combinational path
// runs from ready_in back upstream. A saturating counter records the number
// of cycles in which the output beat was stalled.
//
// Ports
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   valid_in, ready_out : upstream handshake
//   data_in, ctrl_in    : upstream payload
//   valid_out, ready_in : downstream handshake
//   data_out, ctrl_out  : downstream payload (ctrl_out is zero when not valid)
//   flush               : discard all held beats and any incoming beat
//   clr_cnt             : synchronous clear of stall_cnt
//   stall_cnt           : saturating count of cycles with valid_out && !ready_in
// ----------------------------------------------------------------------------
module pip_skid_reg
    import pip_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CTRL_WIDTH = DEF_CTRL_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_in,
    output logic                  ready_out,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [CTRL_WIDTH-1:0] ctrl_in,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [CTRL_WIDTH-1:0] ctrl_out,
    input  logic                  flush,
    input  logic                  clr_cnt,
    output logic [CNT_WIDTH-1:0]  stall_cnt
);

    skid_state_t           r_state;
    skid_state_t           w_next_state;

    logic [DATA_WIDTH-1:0] r_main_data;
    logic [CTRL_WIDTH-1:0] r_main_ctrl;
    logic [DATA_WIDTH-1:0] r_skid_data;
    logic [CTRL_WIDTH-1:0] r_skid_ctrl;

    logic                  w_in_fire;
    logic                  w_out_fire;
    logic                  w_main_from_in;
    logic                  w_main_from_skid;
    logic                  w_skid_from_in;

    // Both handshake flags decode the registered state only.
    assign ready_out  = (r_state != SKID);
    assign valid_out  = (r_state != EMPTY);
    assign w_in_fire  = valid_in && ready_out;
    assign w_out_fire = valid_out && ready_in;

    // Next-state logic and load enables for the storage entries.
    always_comb begin
        // NOTE: every signal assigned here gets a default first. A path that
        // leaves a signal unassigned would infer a latch.
        w_next_state     = r_state;
        w_main_from_in   = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_from_in   = 1'b0;

        unique case (r_state)
            EMPTY: begin
                if (w_in_fire) begin
                    w_main_from_in = 1'b1;
                    w_next_state   = FULL;
                end
            end
            FULL: begin
                if (w_in_fire && w_out_fire) begin
                    w_main_from_in = 1'b1;
                end else if (w_out_fire) begin
                    w_next_state = EMPTY;
                end else if (w_in_fire) begin
                    w_skid_from_in = 1'b1;
                    w_next_state   = SKID;
                end
            end
            SKID: begin
                // ready_out is low here, so only the output side can move.
                if (w_out_fire) begin
                    w_main_from_skid = 1'b1;
                    w_next_state     = FULL;
                end
            end
            default: w_next_state = EMPTY;
        endcase

        // A flush overrides every other event. Any incoming beat is dropped.
        if (flush) begin
            w_next_state     = EMPTY;
            w_main_from_in   = 1'b0;
            w_main_from_skid = 1'b0;
            w_skid_from_in   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: the payload registers are reset even though the valid state
    // already qualifies them. After reset the outputs must read as all zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_data <= '0;
            r_main_ctrl <= '0;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
        end else if (flush) begin
            // Control is zeroed so a killed beat cannot raise a write enable.
            // Stale data is harmless.
            r_main_ctrl <= '0;
            r_skid_ctrl <= '0;
        end else begin
            if (w_main_from_in) begin
                r_main_data <= data_in;
                r_main_ctrl <= ctrl_in;
            end else if (w_main_from_skid) begin
                r_main_data <= r_skid_data;
                r_main_ctrl <= r_skid_ctrl;
            end
            if (w_skid_from_in) begin
                r_skid_data <= data_in;
                r_skid_ctrl <= ctrl_in;
            end
        end
    end

    assign data_out = r_main_data;
    assign ctrl_out = valid_out ? r_main_ctrl : '0;

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (valid_out && !ready_in),
        .clr   (clr_cnt),
        .count (stall_cnt)
    );

endmodule : pip_skid_reg

// File: doc/pip_skid_reg.md
PIP_SKID_REG -- requirements
Module: pip_skid_reg

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of the data payload, e.g. ALU result, PC or memory data.
REQ-002 Parameter CTRL_WIDTH, default 8: width of the control payload, e.g. reg_write_en, data_mem_write_en or write_back_mux.
REQ-003 Parameter CNT_WIDTH, default 16: width of the stall-cycle counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 valid_in  input  1  upstream presents a beat.
REQ-007 ready_out  output  1  block can accept a beat.
REQ-008 data_in  input  DATA_WIDTH  upstream data payload.
REQ-009 ctrl_in  input  CTRL_WIDTH  upstream control payload.
REQ-010 valid_out  output  1  block presents a beat downstream.
REQ-011 ready_in  input  1  downstream accepts a beat; low means stall.
REQ-012 data_out  output  DATA_WIDTH  presented data payload.
REQ-013 ctrl_out  output  CTRL_WIDTH  presented control payload.
REQ-014 flush  input  1  kill all held beats (hazard or branch flush).
REQ-015 clr_cnt  input  1  synchronous clear of the stall counter.
REQ-016 stall_cnt  output  CNT_WIDTH  saturating count of stalled output cycles.

Function
REQ-017 Input fire = valid_in && ready_out; output fire = valid_out && ready_in.
REQ-018 Storage: one main entry driving the outputs and one skid entry; each entry holds data and ctrl.
REQ-019 States: EMPTY (no entry valid), FULL (main valid), SKID (main and skid valid).
REQ-020 ready_out = (state != SKID); it depends only on registered state, with no combinational path from ready_in.
REQ-021 valid_out = (state != EMPTY); data_out = main data; ctrl_out = main ctrl when valid_out = 1, else all zeros.
REQ-022 EMPTY: on input fire, main <= input and next state is FULL; otherwise stay in EMPTY.
REQ-023 FULL, input fire and output fire: main <= input; stay in FULL.
REQ-024 FULL, output fire only: next state is EMPTY.
REQ-025 FULL, input fire only: skid <= input; next state is SKID.
REQ-026 FULL, neither fire: hold all contents.
REQ-027 SKID: on output fire, main <= skid and next state is FULL; otherwise hold.
REQ-028 Latency: a beat accepted into EMPTY appears on the outputs the next cycle; throughput is one beat per cycle while ready_in = 1.
REQ-029 Order is preserved: no beat is dropped or duplicated unless flush is asserted.
REQ-030 flush has priority over all other events: next state is EMPTY, main and skid ctrl are zeroed, any input beat that cycle is discarded, and data registers may hold stale values.
REQ-031 stall_cnt increments by 1 in each cycle where valid_out && !ready_in, and saturates at all-ones.
REQ-032 clr_cnt has priority over an increment in the same cycle: stall_cnt <= 0.
REQ-033 flush does not affect stall_cnt.

Reset
REQ-034 While rst_n = 0: state EMPTY, all data/ctrl registers 0, stall_cnt 0, valid_out 0, ready_out 1.
REQ-035 Reset takes effect immediately, without waiting for a clock edge, and aborts any held beat.
REQ-036 The first input fire is possible on the first rising clk edge after rst_n deasserts.

Structure
REQ-037 The state enum typedef skid_state_t (EMPTY, FULL, SKID) lives in the shared package pip_pkg.
REQ-038 Default width constants also live in pip_pkg, so that all pipeline stages share them.
REQ-039 The stall counter is a sub-module named sat_counter (parameter WIDTH; ports inc, clr, count).
REQ-040 The handshake and storage logic stays in the top module.

Verification
REQ-041 Streaming: ready_in = 1, beats 0x11, 0x22, 0x33 on consecutive cycles -> outputs show 0x11, 0x22, 0x33 one cycle later, ready_out stays 1, stall_cnt = 0.
REQ-042 Stall/skid: two beats 0xA, 0xB sent while ready_in = 0 -> after the second beat ready_out = 0 and data_out = 0xA; ready_in raised -> 0xA then 0xB delivered in order; stall_cnt equals the number of stalled cycles.
REQ-043 Flush in SKID with valid_in = 1 and ctrl_in = 0xFF -> next cycle valid_out = 0, ctrl_out = 0, ready_out = 1, and the input beat is never delivered.
REQ-044 Saturation: CNT_WIDTH = 4, ready_in = 0 with valid_out = 1 for 20 cycles -> stall_cnt = 15; clr_cnt asserted in a stalled cycle -> stall_cnt = 0.
REQ-045 Reset mid-operation: rst_n pulled low in SKID between clock edges -> valid_out = 0, ready_out = 1 and stall_cnt = 0 immediately, with no clock edge.
REQ-046 Random valid_in/ready_in with a scoreboard over 10k cycles, no flush -> output sequence equals input sequence and ready_out never depends combinationally on ready_in.
